// File: rtl/sel_pkg.sv
// ----------------------------------------------------------------------------
// sel_pkg
// Shared constants and types for the 16-way round-robin path-select arbiter.
//   N_PATH     : number of requesters / selectable paths (16)
//   SEL_W      : width of a path select (log2(N_PATH))
//   HOLD_CNT_W : width of the grant-hold watchdog counter
//   arb_state_t: arbiter FSM states
// ----------------------------------------------------------------------------
package sel_pkg;

  localparam int N_PATH     = 16;
  localparam int SEL_W      = 4;
  localparam int HOLD_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick16.sv
// ----------------------------------------------------------------------------
// rr_pick16
// Combinational round-robin winner search over 16 requests. The first set
// request bit at or above ptr wins, wrapping from 15 back to 0.
// Ports:
//   req   in  [15:0] request vector, bit i = path i
//   ptr   in  [3:0]  highest-priority position for this search
//   found out        at least one request is set
//   idx   out [3:0]  winning path index (valid when found)
// ----------------------------------------------------------------------------
module rr_pick16
  import sel_pkg::*;
(
  input  logic [N_PATH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  logic [N_PATH-1:0] rot;
  logic [SEL_W-1:0]  off;

  // Rotate right by ptr so the priority position lands on bit 0; the doubled
  // vector supplies the wrapped-around bits.
  assign rot = N_PATH'({req, req} >> ptr);

  // Lowest set bit of the rotated vector: scan downward so the last hit wins.
  always_comb begin
    off = '0;
    for (int i = N_PATH - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign found = |req;
  // Undo the rotation; the SEL_W-bit add wraps modulo 16.
  assign idx   = off + ptr;

endmodule

// File: rtl/sel4to16.sv
// ----------------------------------------------------------------------------
// sel4to16
// 4-to-16 one-hot path-select decoder.
// Ports:
//   sel    in  [3:0]  binary path index
//   onehot out [15:0] one-hot decode of sel
// ----------------------------------------------------------------------------
module sel4to16 (
  input  logic [3:0]  sel,
  output logic [15:0] onehot
);

  assign onehot = 16'h0001 << sel;

endmodule

// File: rtl/rr_sel16_arbiter.sv
// ----------------------------------------------------------------------------
// rr_sel16_arbiter
// Round-robin arbiter sharing one 16-way path selector among 16 requesters.
// A grant is held until the owner pulses done or drops its request, then one
// RELEASE cycle with no grant is inserted so path switching is
// break-before-make. The next search starts one past the last owner.
//
// Optional build macro SEL_TIMEOUT_EN: adds a hold watchdog that revokes a
// grant after HOLD_MAX cycles and pulses timeout during the RELEASE cycle.
// Without it, timeout is tied low and grants may be held indefinitely.
//
// Ports:
//   clk1        in          rising-edge clock
//   rst_n       in          asynchronous active-low reset
//   req         in  [15:0]  per-requester level request
//   done        in          single-cycle completion pulse from the owner
//   grant_sel   out [3:0]   registered select of current/last owner
//   grant       out [15:0]  one-hot grant, zero unless grant_valid
//   grant_valid out         a grant is active
//   timeout     out         one-cycle pulse when the watchdog revokes a grant
// ----------------------------------------------------------------------------
module rr_sel16_arbiter
  import sel_pkg::*;
#(
  parameter int N_PATH   = 16,
  parameter int SEL_W    = 4,
  parameter int HOLD_MAX = 64
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic [N_PATH-1:0] req,
  input  logic              done,
  output logic [SEL_W-1:0]  grant_sel,
  output logic [N_PATH-1:0] grant,
  output logic              grant_valid,
  output logic              timeout
);

  sel_pkg::arb_state_t state;
  logic [SEL_W-1:0]    ptr;
  logic                found;
  logic [SEL_W-1:0]    pick_idx;
  logic [N_PATH-1:0]   dec;
  logic                owner_release;
  logic                expire;

  rr_pick16 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  sel4to16 u_dec (
    .sel    (grant_sel),
    .onehot (dec)
  );

  // Both registered, so grant only changes right after clk1 edges.
  assign grant = dec & {N_PATH{grant_valid}};

  // done and an owner request drop together still make a single release.
  assign owner_release = done | ~req[grant_sel];

`ifdef SEL_TIMEOUT_EN
  logic [HOLD_CNT_W-1:0] hold_cnt;
  logic                  timeout_q;

  assign expire = (hold_cnt == HOLD_CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      // Held at zero outside GRANT, so it starts from zero on every entry.
      if (state == sel_pkg::GRANT) hold_cnt <= hold_cnt + 1'b1;
      else                         hold_cnt <= '0;
      // An owner release on the expiry cycle wins: no timeout pulse then.
      timeout_q <= (state == sel_pkg::GRANT) && !owner_release && expire;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_hold_max;

  assign unused_hold_max = (HOLD_MAX != 0);
  assign expire          = 1'b0;
  assign timeout         = 1'b0;
`endif

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= sel_pkg::IDLE;
      ptr         <= '0;
      grant_sel   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        sel_pkg::IDLE: begin
          if (found) begin
            grant_sel   <= pick_idx;
            grant_valid <= 1'b1;
            state       <= sel_pkg::GRANT;
          end
        end
        sel_pkg::GRANT: begin
          // No preemption: only the owner (or the watchdog) ends a grant.
          if (owner_release || expire) begin
            grant_valid <= 1'b0;
            state       <= sel_pkg::RELEASE;
          end
        end
        sel_pkg::RELEASE: begin
          ptr   <= grant_sel + SEL_W'(1);
          state <= sel_pkg::IDLE;
        end
        default: begin
          grant_valid <= 1'b0;
          state       <= sel_pkg::IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_sel16_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_sel16_arbiter
// Directed bench for rr_sel16_arbiter. Stimulus pushes the expected owner of
// each upcoming grant into a queue; a monitor pops and compares on every new
// grant. Timing checks (latency, gaps, reset) are made inline.
// ----------------------------------------------------------------------------
module tb_rr_sel16_arbiter;

`ifdef SEL_TIMEOUT_EN
  localparam int HM = 4;
  localparam int EXP_TIMEOUTS = 1;
`else
  localparam int HM = 64;
  localparam int EXP_TIMEOUTS = 0;
`endif

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = 16'h0000;
  logic        done = 1'b0;
  logic [3:0]  grant_sel;
  logic [15:0] grant;
  logic        grant_valid;
  logic        timeout;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          to_seen = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_sel;
  logic        prev_gv = 1'b0;

  rr_sel16_arbiter #(.N_PATH(16), .SEL_W(4), .HOLD_MAX(HM)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant_sel   (grant_sel),
    .grant       (grant),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk1 = ~clk1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_gv(input logic v, input int budget, input string name);
    int n = 0;
    while (grant_valid !== v && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(grant_valid), 32'(v));
  endtask

  // Monitor: one scoreboard entry per new grant.
  always @(negedge clk1) begin
    if (timeout === 1'b1) to_seen++;
    if (grant_valid === 1'b1 && prev_gv !== 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_grant: got sel %0d, expected no grant", grant_sel);
      end else begin
        exp_sel = exp_q.pop_front();
        check("grant_sel", 32'(grant_sel), 32'(exp_sel));
        check("grant_onehot", 32'(grant), 32'(16'h0001 << exp_sel));
      end
    end
    prev_gv = grant_valid;
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_grant_valid", 32'(grant_valid), 32'(1'b0));
    check("rst_grant", 32'(grant), 32'(16'h0000));
    check("rst_grant_sel", 32'(grant_sel), 32'(4'd0));
    check("rst_timeout", 32'(timeout), 32'(1'b0));
    rst_n = 1'b1;
    tick();

    // Reset in the middle of a grant to path 5
    req = 16'h0020;
    exp_q.push_back(4'd5);
    tick();
    check("lat_first", 32'(grant_valid), 32'(1'b1));
    check("grant_0020", 32'(grant), 32'(16'h0020));
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_gv", 32'(grant_valid), 32'(1'b0));
    check("async_rst_grant", 32'(grant), 32'(16'h0000));
    req = 16'h0000;
    tick();
    rst_n = 1'b1;
    tick();
    req = 16'h0001;
    exp_q.push_back(4'd0);
    tick();
    check("post_rst_gv", 32'(grant_valid), 32'(1'b1));
    done = 1'b1;
    req = 16'h0000;
    tick();
    done = 1'b0;
    check("post_rst_release", 32'(grant_valid), 32'(1'b0));
    tick();

    // Single requester 3: hold, release, re-grant after a 2-cycle gap
    req = 16'h0008;
    exp_q.push_back(4'd3);
    tick();
    check("single_lat", 32'(grant_valid), 32'(1'b1));
    repeat (4) tick();
    check("single_hold", 32'(grant_valid), 32'(1'b1));
    done = 1'b1;
    exp_q.push_back(4'd3);
    tick();
    done = 1'b0;
    check("single_gap1", 32'(grant_valid), 32'(1'b0));
    tick();
    check("single_gap2", 32'(grant_valid), 32'(1'b0));
    tick();
    check("single_regrant", 32'(grant_valid), 32'(1'b1));
    done = 1'b1;
    req = 16'h0000;
    tick();
    done = 1'b0;
    repeat (3) tick();
    check("idle_no_grant", 32'(grant_valid), 32'(1'b0));

    // Round robin over all 16 with wrap; reset first so ptr is 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req = 16'hFFFF;
    for (int i = 0; i < 17; i++) exp_q.push_back(4'(i % 16));
    for (int k = 0; k < 17; k++) begin
      wait_gv(1'b1, 6, "rr_grant");
      tick();
      done = 1'b1;
      if (k == 16) req = 16'h0000;
      tick();
      done = 1'b0;
    end
    tick();
    tick();

    // Pointer skip: grant 13 so ptr becomes 14, then req 0006 -> 1, then 2
    req = 16'h2000;
    exp_q.push_back(4'd13);
    wait_gv(1'b1, 6, "skip_setup");
    done = 1'b1;
    req = 16'h0000;
    tick();
    done = 1'b0;
    tick();
    req = 16'h0006;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    wait_gv(1'b1, 6, "skip_grant1");
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_gv(1'b1, 6, "skip_grant2");
    done = 1'b1;
    req = 16'h0000;
    tick();
    done = 1'b0;
    tick();
    tick();

    // Withdrawal: owner 7 drops its request, pending 9 granted 2 cycles later
    req = 16'h0280;
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd9);
    wait_gv(1'b1, 6, "wd_grant7");
    tick();
    req = 16'h0200;
    tick();
    check("wd_release", 32'(grant_valid), 32'(1'b0));
    tick();
    check("wd_idle", 32'(grant_valid), 32'(1'b0));
    tick();
    check("wd_regrant", 32'(grant_valid), 32'(1'b1));
    done = 1'b1;
    req = 16'h0000;
    tick();
    done = 1'b0;
    tick();
    tick();

`ifdef SEL_TIMEOUT_EN
    // Watchdog: 4-cycle hold, timeout pulse in RELEASE, then re-arbitration
    begin
      int n = 0;
      req = 16'h0010;
      exp_q.push_back(4'd4);
      exp_q.push_back(4'd4);
      tick();
      check("to_grant", 32'(grant_valid), 32'(1'b1));
      while (grant_valid === 1'b1 && n < 20) begin
        n++;
        tick();
      end
      check("to_hold_len", 32'(n), 32'd4);
      check("to_pulse", 32'(timeout), 32'(1'b1));
      tick();
      check("to_pulse_end", 32'(timeout), 32'(1'b0));
      check("to_idle_gv", 32'(grant_valid), 32'(1'b0));
      tick();
      check("to_regrant", 32'(grant_valid), 32'(1'b1));
      req = 16'h0000;
      repeat (3) tick();
    end
`else
    // No watchdog: a grant without done is held indefinitely
    req = 16'h0010;
    exp_q.push_back(4'd4);
    tick();
    check("hold_grant", 32'(grant_valid), 32'(1'b1));
    repeat (70) tick();
    check("hold_unbounded", 32'(grant_valid), 32'(1'b1));
    check("hold_no_timeout", 32'(to_seen), 32'd0);
    done = 1'b1;
    req = 16'h0000;
    tick();
    done = 1'b0;
    repeat (3) tick();
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("timeout_count", 32'(to_seen), 32'(EXP_TIMEOUTS));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
